ntt_sdf_reorder: RTL and testbench

- Converts the bit-reversed serial output of the SDF NTT/INTT pipeline into a natural-order coefficient stream.
- Sits directly downstream of the SDF stage chain and consumes its finish pulse and output data word.
- Uses ping-pong buffering of two N-word banks, so back-to-back polynomials stream at one coefficient per cycle with no stall.

---
 rtl/ntt_sdf_reorder.sv | 167 ++++++++++++++++
 tb/tb_ntt_sdf_reorder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sdf_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_sdf_reorder
//  Purpose  : Turns the bit-reversed serial output of the SDF NTT/INTT chain
//             into a natural-order coefficient stream. Two N-word banks are
//             used ping-pong so that one frame can be written while the
//             previous one drains, giving one coefficient per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ntt_sdf_reorder #(
    parameter int LOGQ = 32,
    parameter int LOGN = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_start,
    input  logic [LOGQ-1:0] din,
    input  logic            bypass,
    output logic            out_start,
    output logic            out_valid,
    output logic [LOGQ-1:0] dout,
    output logic            busy
);

    localparam int              N        = 1 << LOGN;
    localparam logic [LOGN-1:0] LAST_IDX = {LOGN{1'b1}};

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DRAIN = 1'b1} rstate_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = a[LOGN-1-i];
        end
        return r;
    endfunction

    // Both banks share one array; the top address bit selects the bank.
    logic [LOGQ-1:0] mem_q [0:2*N-1];

    wstate_t         w_state_q, w_state_d;
    logic [LOGN-1:0] wcnt_q, wcnt_d;
    logic            wbank_q, wbank_d;
    logic            byp_q, byp_d;

    rstate_t         r_state_q, r_state_d;
    logic [LOGN-1:0] rcnt_q, rcnt_d;
    logic            rbank_q, rbank_d;

    logic            w_we;
    logic [LOGN-1:0] w_idx;
    logic            w_byp;
    logic            handoff;
    logic [LOGN:0]   waddr;
    logic            r_drain;
    logic [LOGQ-1:0] rd_q;
    logic            out_valid_q;
    logic            out_start_q;

    // Write side next state: in_start always restarts a frame in the current bank.
    always_comb begin
        w_state_d = w_state_q;
        wcnt_d    = wcnt_q;
        wbank_d   = wbank_q;
        byp_d     = byp_q;
        w_we      = 1'b0;
        w_idx     = wcnt_q;
        w_byp     = byp_q;
        handoff   = 1'b0;
        if (in_start) begin
            w_we      = 1'b1;
            w_idx     = '0;
            w_byp     = bypass;
            byp_d     = bypass;
            w_state_d = W_FILL;
            wcnt_d    = LOGN'(1);
        end else if (w_state_q == W_FILL) begin
            w_we   = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST_IDX) begin
                handoff   = 1'b1;
                wbank_d   = ~wbank_q;
                w_state_d = W_IDLE;
            end
        end
    end

    assign waddr = {wbank_q, (w_byp ? w_idx : bitrev(w_idx))};

    // Write-side state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            wcnt_q    <= '0;
            wbank_q   <= 1'b0;
            byp_q     <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            wcnt_q    <= wcnt_d;
            wbank_q   <= wbank_d;
            byp_q     <= byp_d;
        end
    end

    // Read side next state: a hand-off (re)starts the drain on the filled bank,
    // which also covers a hand-off landing on the last drain address.
    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rbank_d   = rbank_q;
        if (handoff) begin
            r_state_d = R_DRAIN;
            rcnt_d    = '0;
            rbank_d   = wbank_q;
        end else if (r_state_q == R_DRAIN) begin
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == LAST_IDX) begin
                r_state_d = R_IDLE;
            end
        end
    end

    assign r_drain = (r_state_q == R_DRAIN);

    // Read-side state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rcnt_q    <= '0;
            rbank_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rcnt_q    <= rcnt_d;
            rbank_q   <= rbank_d;
        end
    end

    // Bank storage with synchronous read; kept reset-free so it maps to RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[waddr] <= din;
        end
        if (r_drain) begin
            rd_q <= mem_q[{rbank_q, rcnt_q}];
        end
    end

    // Output qualifiers aligned with the registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
        end else begin
            out_valid_q <= r_drain;
            out_start_q <= r_drain && (rcnt_q == '0);
        end
    end

    // Masking with out_valid forces dout to zero as soon as reset asserts.
    assign dout      = out_valid_q ? rd_q : '0;
    assign out_valid = out_valid_q;
    assign out_start = out_start_q;
    assign busy      = (w_state_q != W_IDLE) | (r_state_q != R_IDLE) | out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_sdf_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_sdf_reorder
//  Purpose  : Self-checking bench for ntt_sdf_reorder (LOGN=3 and LOGN=5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_sdf_reorder;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_start3, bypass3, out_start3, out_valid3, busy3;
    logic [15:0] din3, dout3;
    logic        in_start5, bypass5, out_start5, out_valid5, busy5;
    logic [31:0] din5, dout5;

    logic [15:0] exp3_q [$];
    logic [31:0] exp5_q [$];
    logic [15:0] e3;
    logic [31:0] e5;

    int n_checks = 0;
    int n_pass   = 0;
    int vcnt3 = 0, scnt3 = 0, vcnt5 = 0, scnt5 = 0;

    always #5 clk = ~clk;

    ntt_sdf_reorder #(.LOGQ(16), .LOGN(3)) dut3 (
        .clk(clk), .rst(rst), .in_start(in_start3), .din(din3), .bypass(bypass3),
        .out_start(out_start3), .out_valid(out_valid3), .dout(dout3), .busy(busy3)
    );

    ntt_sdf_reorder #(.LOGQ(32), .LOGN(5)) dut5 (
        .clk(clk), .rst(rst), .in_start(in_start5), .din(din5), .bypass(bypass5),
        .out_start(out_start5), .out_valid(out_valid5), .dout(dout5), .busy(busy5)
    );

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Scoreboard for the LOGN=3 instance.
    always @(negedge clk) begin
        if (!rst && out_valid3) begin
            vcnt3++;
            n_checks++;
            if (exp3_q.size() == 0) begin
                $display("FAIL dout3_unexpected: got %0d, required no output", dout3);
            end else begin
                e3 = exp3_q.pop_front();
                if (dout3 !== e3) $display("FAIL dout3: got %0d, required %0d", dout3, e3);
                else n_pass++;
            end
        end
        if (!rst && out_start3) scnt3++;
    end

    // Scoreboard for the LOGN=5 instance.
    always @(negedge clk) begin
        if (!rst && out_valid5) begin
            vcnt5++;
            n_checks++;
            if (exp5_q.size() == 0) begin
                $display("FAIL dout5_unexpected: got %0h, required no output", dout5);
            end else begin
                e5 = exp5_q.pop_front();
                if (dout5 !== e5) $display("FAIL dout5: got %0h, required %0h", dout5, e5);
                else n_pass++;
            end
        end
        if (!rst && out_start5) scnt5++;
    end

    task automatic step3(input logic s, input logic [15:0] d, input logic b);
        @(posedge clk); #1;
        in_start3 = s; din3 = d; bypass3 = b;
        @(negedge clk);
    endtask

    task automatic step5(input logic s, input logic [31:0] d, input logic b);
        @(posedge clk); #1;
        in_start5 = s; din5 = d; bypass5 = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({out_start3, out_valid3, busy3, dout3} !== 19'd0)
            $display("FAIL reset3: got st=%0b v=%0b busy=%0b dout=%0d, required all 0", out_start3, out_valid3, busy3, dout3);
        else n_pass++;
        n_checks++;
        if ({out_start5, out_valid5, busy5, dout5} !== 35'd0)
            $display("FAIL reset5: got st=%0b v=%0b busy=%0b dout=%0h, required all 0", out_start5, out_valid5, busy5, dout5);
        else n_pass++;
    endtask

    task automatic test_reorder(input logic b);
        vcnt3 = 0; scnt3 = 0;
        for (int c = 0; c <= 20; c++) begin
            step3(c == 0, (c < 8) ? 16'(c) : 16'hDEAD, (c == 0) ? b : ~b);
            if (c == 7) for (int k = 0; k < 8; k++) exp3_q.push_back(b ? 16'(k) : 16'(brev(k, 3)));
            n_checks++;
            if (out_valid3 !== (c >= 9 && c <= 16)) $display("FAIL reorder_valid c=%0d: got %0b, required %0b", c, out_valid3, (c >= 9 && c <= 16));
            else n_pass++;
            n_checks++;
            if (out_start3 !== (c == 9)) $display("FAIL reorder_start c=%0d: got %0b, required %0b", c, out_start3, (c == 9));
            else n_pass++;
            n_checks++;
            if (busy3 !== (c >= 1 && c <= 16)) $display("FAIL reorder_busy c=%0d: got %0b, required %0b", c, busy3, (c >= 1 && c <= 16));
            else n_pass++;
        end
        n_checks++;
        if (vcnt3 != 8 || scnt3 != 1) $display("FAIL reorder_count: got valid=%0d starts=%0d, required 8 and 1", vcnt3, scnt3);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        vcnt3 = 0; scnt3 = 0;
        for (int c = 0; c <= 40; c++) begin
            step3((c % 8 == 0) && (c < 24), (c < 24) ? 16'(8 * (c / 8) + (c % 8)) : 16'h0, 1'b0);
            if ((c % 8 == 7) && (c < 24))
                for (int k = 0; k < 8; k++) exp3_q.push_back(16'(8 * (c / 8) + brev(k, 3)));
            n_checks++;
            if (out_valid3 !== (c >= 9 && c <= 32)) $display("FAIL b2b_valid c=%0d: got %0b, required %0b", c, out_valid3, (c >= 9 && c <= 32));
            else n_pass++;
            n_checks++;
            if (out_start3 !== (c == 9 || c == 17 || c == 25)) $display("FAIL b2b_start c=%0d: got %0b, required %0b", c, out_start3, (c == 9 || c == 17 || c == 25));
            else n_pass++;
        end
        n_checks++;
        if (vcnt3 != 24 || scnt3 != 3) $display("FAIL b2b_count: got valid=%0d starts=%0d, required 24 and 3", vcnt3, scnt3);
        else n_pass++;
    endtask

    task automatic test_truncated();
        vcnt3 = 0; scnt3 = 0;
        for (int c = 0; c <= 26; c++) begin
            step3(c == 0 || c == 5, (c < 5) ? 16'(c) : ((c <= 12) ? 16'(10 + c - 5) : 16'h0), 1'b0);
            if (c == 12) for (int k = 0; k < 8; k++) exp3_q.push_back(16'(10 + brev(k, 3)));
            n_checks++;
            if (out_valid3 !== (c >= 14 && c <= 21)) $display("FAIL trunc_valid c=%0d: got %0b, required %0b", c, out_valid3, (c >= 14 && c <= 21));
            else n_pass++;
            n_checks++;
            if (out_start3 !== (c == 14)) $display("FAIL trunc_start c=%0d: got %0b, required %0b", c, out_start3, (c == 14));
            else n_pass++;
        end
        n_checks++;
        if (vcnt3 != 8 || scnt3 != 1) $display("FAIL trunc_count: got valid=%0d starts=%0d, required 8 and 1", vcnt3, scnt3);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        for (int c = 0; c <= 11; c++) begin
            step3(c == 0, (c < 8) ? 16'(50 + c) : 16'h0, 1'b0);
            if (c == 7) for (int k = 0; k < 8; k++) exp3_q.push_back(16'(50 + brev(k, 3)));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        exp3_q.delete();
        exp5_q.delete();
        n_checks++;
        if ({out_valid3, out_start3, busy3, dout3} !== 19'd0)
            $display("FAIL rst_mid_drain: got v=%0b st=%0b busy=%0b dout=%0d, required all 0", out_valid3, out_start3, busy3, dout3);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        vcnt3 = 0; scnt3 = 0;
        for (int c = 0; c <= 20; c++) begin
            step3(c == 0, (c < 8) ? 16'(100 + c) : 16'h0, 1'b0);
            if (c == 7) for (int k = 0; k < 8; k++) exp3_q.push_back(16'(100 + brev(k, 3)));
            n_checks++;
            if (out_valid3 !== (c >= 9 && c <= 16)) $display("FAIL post_rst_valid c=%0d: got %0b, required %0b", c, out_valid3, (c >= 9 && c <= 16));
            else n_pass++;
            n_checks++;
            if (out_start3 !== (c == 9)) $display("FAIL post_rst_start c=%0d: got %0b, required %0b", c, out_start3, (c == 9));
            else n_pass++;
        end
        n_checks++;
        if (vcnt3 != 8 || scnt3 != 1) $display("FAIL post_rst_count: got valid=%0d starts=%0d, required 8 and 1", vcnt3, scnt3);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] fr [32];
        logic        b;
        int          gap;
        vcnt5 = 0; scnt5 = 0;
        for (int f = 0; f < 6; f++) begin
            b   = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(32, 44));
            for (int k = 0; k < 32; k++) fr[k] = $urandom;
            for (int c = 0; c < gap; c++) begin
                step5(c == 0, (c < 32) ? fr[c] : $urandom, (c == 0) ? b : 1'($urandom_range(0, 1)));
                if (c == 31) for (int k = 0; k < 32; k++) exp5_q.push_back(b ? fr[k] : fr[brev(k, 5)]);
            end
        end
        for (int c = 0; c < 80; c++) step5(1'b0, $urandom, 1'b0);
        n_checks++;
        if (vcnt5 != 6 * 32 || scnt5 != 6) $display("FAIL random_count: got valid=%0d starts=%0d, required 192 and 6", vcnt5, scnt5);
        else n_pass++;
        n_checks++;
        if (exp5_q.size() != 0 || busy5 !== 1'b0) $display("FAIL random_drain: got left=%0d busy=%0b, required 0 and 0", exp5_q.size(), busy5);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        in_start3 = 1'b0; din3 = '0; bypass3 = 1'b0;
        in_start5 = 1'b0; din5 = '0; bypass5 = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        test_reorder(1'b0);
        test_reorder(1'b1);
        test_back_to_back();
        test_truncated();
        test_reset_mid_drain();
        test_random();
        n_checks++;
        if (exp3_q.size() != 0) $display("FAIL leftover3: got %0d pending, required 0", exp3_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
